uart_cmd_ctrl: RTL



---
 rtl/uart_cmd_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind uart_rx: validates A5-framed commands, streams write payloads
// to the framebuffer port and holds the panel brightness register.
module uart_cmd_ctrl #(
  parameter int          addr_width      = 10,
  parameter int          timeout         = 20480,
  parameter logic [7:0]  brightness_init = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data,
  input  logic                  valid,
  output logic [addr_width-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  wr_en,
  output logic [7:0]            brightness,
  output logic                  busy,
  output logic                  frame_ok,
  output logic                  frame_err
);

  localparam int tw = $clog2(timeout + 1);
  localparam logic [tw-1:0] to_max = tw'(timeout);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_LEN, S_PAYLOAD, S_CSUM
  } state_t;

  state_t                state, state_n;
  logic [tw-1:0]         tcnt;
  logic                  is_wr, len_one, first;
  logic [7:0]            addr_hi, rem, cand, csum;
  logic [addr_width-1:0] ptr;
  logic                  to_hit, ok_n, err_n, wr_n, bright_ld;

  assign busy   = (state != S_IDLE);
  // A byte arriving on the boundary cycle takes priority over the timeout.
  assign to_hit = busy && !valid && (tcnt == to_max);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    wr_n      = 1'b0;
    bright_ld = 1'b0;
    if (to_hit) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else if (valid) begin
      case (state)
        S_IDLE:    if (data == 8'hA5) state_n = S_CMD;
        S_CMD: begin
          if (data == 8'h01 || data == 8'h02) state_n = S_ADDR_HI;
          else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_ADDR_HI: state_n = S_ADDR_LO;
        S_ADDR_LO: state_n = S_LEN;
        S_LEN:     state_n = (data == 8'd0) ? S_CSUM : S_PAYLOAD;
        S_PAYLOAD: begin
          wr_n = is_wr;
          if (rem == 8'd1) state_n = S_CSUM;
        end
        S_CSUM: begin
          if (data == csum && (is_wr || len_one)) begin
            ok_n      = 1'b1;
            bright_ld = !is_wr;
          end else begin
            err_n = 1'b1;
          end
          state_n = S_IDLE;
        end
        default:   state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      brightness <= brightness_init;
      is_wr      <= 1'b0;
      len_one    <= 1'b0;
      first      <= 1'b0;
      addr_hi    <= 8'h00;
      rem        <= 8'h00;
      cand       <= 8'h00;
      csum       <= 8'h00;
      ptr        <= '0;
    end else begin
      frame_ok  <= ok_n;
      frame_err <= err_n;
      wr_en     <= wr_n;
      if (valid || !busy || to_hit) tcnt <= '0;
      else                          tcnt <= tcnt + tw'(1);
      if (wr_n) begin
        wr_addr <= ptr;
        wr_data <= data;
        ptr     <= ptr + addr_width'(1);
      end
      if (bright_ld) brightness <= cand;
      if (valid && !to_hit) begin
        case (state)
          S_IDLE:    csum <= 8'h00;
          S_CMD: begin
            is_wr <= (data == 8'h01);
            csum  <= csum ^ data;
          end
          S_ADDR_HI: begin
            addr_hi <= data;
            csum    <= csum ^ data;
          end
          S_ADDR_LO: begin
            ptr  <= addr_width'({addr_hi, data});
            csum <= csum ^ data;
          end
          S_LEN: begin
            rem     <= data;
            len_one <= (data == 8'd1);
            first   <= 1'b1;
            csum    <= csum ^ data;
          end
          S_PAYLOAD: begin
            rem   <= rem - 8'd1;
            first <= 1'b0;
            if (first) cand <= data;
            csum  <= csum ^ data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
